// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: state encodings, opcode constants and the default reset vector
// shared by the PC sequencer and its return stack. The CALL/RET opcodes only
// have a special meaning when CALL_STACK_EN is defined.
package pc_seq_pkg;

    localparam logic [2:0] ST_INIT_ENC     = 3'd0;
    localparam logic [2:0] ST_FETCH_ENC    = 3'd1;
    localparam logic [2:0] ST_DECODE_ENC   = 3'd2;
    localparam logic [2:0] ST_FETCH_OP_ENC = 3'd3;
    localparam logic [2:0] ST_EXEC_ENC     = 3'd4;
    localparam logic [2:0] ST_HALT_ENC     = 3'd5;

    typedef enum logic [2:0] {
        ST_INIT     = ST_INIT_ENC,
        ST_FETCH    = ST_FETCH_ENC,
        ST_DECODE   = ST_DECODE_ENC,
        ST_FETCH_OP = ST_FETCH_OP_ENC,
        ST_EXEC     = ST_EXEC_ENC,
        ST_HALT     = ST_HALT_ENC
    } seqState_t;

    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_BZ   = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hF;
    localparam logic [3:0] OP_CALL = 4'hC;
    localparam logic [3:0] OP_RET  = 4'hB;

    localparam logic [7:0] RESET_VECTOR_DEFAULT = 8'h00;

endpackage

// File: rtl/pc_return_stack.sv
// pc_return_stack: LIFO of return addresses used by CALL/RET. Only instantiated
// when CALL_STACK_EN is defined. The sequencer never pushes when full or pops
// when empty, but the stack guards against it anyway so it cannot corrupt itself.
module pc_return_stack
    import pc_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]    r_count;
    logic [IW-1:0]    w_wrIdx;
    logic [IW-1:0]    w_rdIdx;

    assign w_wrIdx = r_count[IW-1:0];
    assign w_rdIdx = w_wrIdx - IW'(1);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[w_rdIdx];

    // Entry count doubles as the write pointer; the top of stack sits just below it.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_push && !o_full) begin
            r_mem[w_wrIdx] <= i_data;
            r_count        <= r_count + CW'(1);
        end else if (i_pop && !o_empty) begin
            r_count <= r_count - CW'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle control FSM owning the program counter. Sequences
// fetch, decode, operand fetch and execute, and resolves JMP/BZ targets.
// Optional feature macro: CALL_STACK_EN adds CALL/RET with a return stack.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(RESET_VECTOR_DEFAULT),
    parameter int               STACK_DEPTH  = 4
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_pcOut,
    input  logic [WIDTH-1:0] i_instr,
    input  logic             i_memReady,
    input  logic             i_zero,
    input  logic             i_execDone,
    output logic [WIDTH-1:0] o_pcIn,
    output logic             o_pcWrite,
    output logic             o_memRead,
    output logic             o_irWrite,
    output logic             o_execEn,
    output logic             o_halted
);

    if (STACK_DEPTH < 1) begin : gDepthCheck
        $error("pc_sequencer: STACK_DEPTH must be at least 1");
    end

    seqState_t        r_state;
    seqState_t        w_stateNext;
    logic [3:0]       r_opcode;
    logic [WIDTH-1:0] w_pcPlusOne;

    assign w_pcPlusOne = i_pcOut + WIDTH'(1);

`ifdef CALL_STACK_EN
    logic             w_push;
    logic             w_pop;
    logic             w_stackFull;
    logic             w_stackEmpty;
    logic [WIDTH-1:0] w_stackTop;

    pc_return_stack #(
        .WIDTH (WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_returnStack (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_pcPlusOne),
        .o_data  (w_stackTop),
        .o_full  (w_stackFull),
        .o_empty (w_stackEmpty)
    );
`endif

    // State register; reset forces INIT immediately, even mid-instruction.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Opcode is captured together with the instruction register load.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_opcode <= '0;
        end else if (r_state == ST_FETCH && i_memReady) begin
            r_opcode <= i_instr[WIDTH-1 -: 4];
        end
    end

    // Next-state and output decode; PC is written only in INIT, FETCH, FETCH_OP and RET.
    always_comb begin
        w_stateNext = r_state;
        o_pcIn      = '0;
        o_pcWrite   = 1'b0;
        o_memRead   = 1'b0;
        o_irWrite   = 1'b0;
        o_execEn    = 1'b0;
        o_halted    = 1'b0;
`ifdef CALL_STACK_EN
        w_push      = 1'b0;
        w_pop       = 1'b0;
`endif
        case (r_state)
            ST_INIT: begin
                o_pcWrite   = 1'b1;
                o_pcIn      = RESET_VECTOR;
                w_stateNext = ST_FETCH;
            end
            ST_FETCH: begin
                o_memRead = 1'b1;
                if (i_memReady) begin
                    o_irWrite   = 1'b1;
                    o_pcWrite   = 1'b1;
                    o_pcIn      = w_pcPlusOne;
                    w_stateNext = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (r_opcode == OP_HALT) begin
                    w_stateNext = ST_HALT;
                end else if (r_opcode == OP_JMP || r_opcode == OP_BZ) begin
                    w_stateNext = ST_FETCH_OP;
`ifdef CALL_STACK_EN
                end else if (r_opcode == OP_CALL) begin
                    w_stateNext = ST_FETCH_OP;
                end else if (r_opcode == OP_RET) begin
                    if (w_stackEmpty) begin
                        w_stateNext = ST_HALT;
                    end else begin
                        o_pcWrite   = 1'b1;
                        o_pcIn      = w_stackTop;
                        w_pop       = 1'b1;
                        w_stateNext = ST_FETCH;
                    end
`endif
                end else begin
                    w_stateNext = ST_EXEC;
                end
            end
            ST_FETCH_OP: begin
                o_memRead = 1'b1;
                if (i_memReady) begin
`ifdef CALL_STACK_EN
                    if (r_opcode == OP_CALL && w_stackFull) begin
                        w_stateNext = ST_HALT;
                    end else begin
`endif
                        o_pcWrite   = 1'b1;
                        w_stateNext = ST_FETCH;
                        if (r_opcode == OP_BZ && !i_zero) begin
                            o_pcIn = w_pcPlusOne;
                        end else begin
                            o_pcIn = i_instr;
                        end
`ifdef CALL_STACK_EN
                        w_push = (r_opcode == OP_CALL);
                    end
`endif
                end
            end
            ST_EXEC: begin
                o_execEn = 1'b1;
                if (i_execDone) begin
                    w_stateNext = ST_FETCH;
                end
            end
            ST_HALT: begin
                o_halted = 1'b1;
            end
            default: begin
                w_stateNext = ST_INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed bench for pc_sequencer with RESET_VECTOR=8'h10.
// The bench owns the PC register and drives memory/datapath handshakes per cycle.
// Build with CALL_STACK_EN defined to exercise CALL/RET.
module tb_pc_sequencer;

    localparam logic [7:0] F_PCW = 8'h01;
    localparam logic [7:0] F_MRD = 8'h02;
    localparam logic [7:0] F_IRW = 8'h04;
    localparam logic [7:0] F_EXE = 8'h08;
    localparam logic [7:0] F_HLT = 8'h10;

    logic       clock    = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] pcReg    = 8'h00;
    logic [7:0] instr    = 8'h00;
    logic       memReady = 1'b0;
    logic       zero     = 1'b0;
    logic       execDone = 1'b0;

    logic [7:0] pcIn;
    logic       pcWrite;
    logic       memRead;
    logic       irWrite;
    logic       execEn;
    logic       halted;
    logic [7:0] flags;

    int vectorCount = 0;
    int missCount   = 0;

    assign flags = {3'b000, halted, execEn, irWrite, memRead, pcWrite};

    // Free-running clock, 10 time units per cycle.
    always #5 clock = ~clock;

    pc_sequencer #(
        .WIDTH        (8),
        .RESET_VECTOR (8'h10),
        .STACK_DEPTH  (4)
    ) dut (
        .i_clock    (clock),
        .i_reset    (reset),
        .i_pcOut    (pcReg),
        .i_instr    (instr),
        .i_memReady (memReady),
        .i_zero     (zero),
        .i_execDone (execDone),
        .o_pcIn     (pcIn),
        .o_pcWrite  (pcWrite),
        .o_memRead  (memRead),
        .o_irWrite  (irWrite),
        .o_execEn   (execEn),
        .o_halted   (halted)
    );

    // Environment PC register, loaded whenever the sequencer asserts PCWrite.
    always @(posedge clock) begin
        if (pcWrite) pcReg <= pcIn;
    end

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic mr, input logic [7:0] ins, input logic z, input logic ed);
        memReady = mr;
        instr    = ins;
        zero     = z;
        execDone = ed;
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic midCycle();
        @(negedge clock);
    endtask

    // Opcode fetch with optional wait states; ends in the DECODE cycle's posedge+1.
    task automatic fetchOpcode(input string tag, input logic [7:0] op, input int waits,
                               input logic [7:0] expPc, input logic [7:0] expMid);
        checkOutput({tag, "_pc"}, pcReg, expPc);
        for (int w = 0; w < waits; w++) begin
            applyStimulus(1'b0, op, 1'b0, 1'b1);
            midCycle();
            checkOutput({tag, "_waitFlags"}, flags, F_MRD);
            nextCycle();
        end
        applyStimulus(1'b1, op, 1'b0, 1'b1);
        midCycle();
        checkOutput({tag, "_fetchFlags"}, flags, F_MRD | F_IRW | F_PCW);
        checkOutput({tag, "_fetchPcIn"}, pcIn, expMid);
        nextCycle();
    endtask

    task automatic doSimple(input string tag, input logic [7:0] op, input int waits, input int execCycles,
                            input logic [7:0] expPc, input logic [7:0] expNext);
        fetchOpcode(tag, op, waits, expPc, expNext);
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
        midCycle();
        checkOutput({tag, "_decodeFlags"}, flags, 8'h00);
        nextCycle();
        for (int e = 0; e < execCycles; e++) begin
            applyStimulus(1'b1, 8'h00, 1'b0, (e == execCycles - 1));
            midCycle();
            checkOutput({tag, "_execFlags"}, flags, F_EXE);
            nextCycle();
        end
        checkOutput({tag, "_nextPc"}, pcReg, expNext);
    endtask

    task automatic doTwoByte(input string tag, input logic [7:0] op, input logic [7:0] operand, input logic z,
                             input logic [7:0] expPc, input logic [7:0] expMid, input logic [7:0] expFinal);
        fetchOpcode(tag, op, 0, expPc, expMid);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        midCycle();
        checkOutput({tag, "_decodeFlags"}, flags, 8'h00);
        checkOutput({tag, "_decodePcIn"}, pcIn, 8'h00);
        nextCycle();
        applyStimulus(1'b1, operand, z, 1'b1);
        midCycle();
        checkOutput({tag, "_opFlags"}, flags, F_MRD | F_PCW);
        checkOutput({tag, "_opPcIn"}, pcIn, expFinal);
        nextCycle();
        checkOutput({tag, "_finalPc"}, pcReg, expFinal);
    endtask

    task automatic doHalt(input logic [7:0] expPc, input logic [7:0] expMid);
        fetchOpcode("halt", 8'hF0, 0, expPc, expMid);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        midCycle();
        checkOutput("halt_decodeFlags", flags, 8'h00);
        nextCycle();
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1'b1, 8'hE0, 1'b1, 1'b1);
            midCycle();
            checkOutput("halt_heldFlags", flags, F_HLT);
            nextCycle();
        end
        checkOutput("halt_pcFrozen", pcReg, expMid);
    endtask

    // Async reset from any state: INIT outputs appear before the next clock edge.
    task automatic doReset(input string tag);
        reset = 1'b1;
        #1;
        checkOutput({tag, "_asyncFlags"}, flags, F_PCW);
        checkOutput({tag, "_asyncPcIn"}, pcIn, 8'h10);
        nextCycle();
        reset = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        midCycle();
        checkOutput({tag, "_initFlags"}, flags, F_PCW);
        checkOutput({tag, "_initPcIn"}, pcIn, 8'h10);
        nextCycle();
        checkOutput({tag, "_fetchPc"}, pcReg, 8'h10);
    endtask

    initial begin
        $display("[TB] pc_sequencer directed test start");

        for (int i = 0; i < 3; i++) begin
            midCycle();
            checkOutput("rst_flags", flags, F_PCW);
            checkOutput("rst_pcIn", pcIn, 8'h10);
            nextCycle();
        end
        reset = 1'b0;
        midCycle();
        checkOutput("init_flags", flags, F_PCW);
        checkOutput("init_pcIn", pcIn, 8'h10);
        nextCycle();
        midCycle();
        checkOutput("firstFetch_flags", flags, F_MRD);
        nextCycle();

        doSimple("simpleWait", 8'h35, 2, 2, 8'h10, 8'h11);
        doTwoByte("jmpA", 8'hE0, 8'h20, 1'b0, 8'h11, 8'h12, 8'h20);
        doTwoByte("jmpSpec", 8'hE5, 8'h80, 1'b0, 8'h20, 8'h21, 8'h80);
        doTwoByte("jmpB", 8'hE0, 8'h40, 1'b0, 8'h80, 8'h81, 8'h40);
        doTwoByte("bzNotTaken", 8'hD0, 8'h90, 1'b0, 8'h40, 8'h41, 8'h42);
        doTwoByte("jmpC", 8'hE0, 8'h40, 1'b0, 8'h42, 8'h43, 8'h40);
        doTwoByte("bzTaken", 8'hD3, 8'h90, 1'b1, 8'h40, 8'h41, 8'h90);
        doTwoByte("jmpFF", 8'hE0, 8'hFF, 1'b0, 8'h90, 8'h91, 8'hFF);
        doSimple("wrap", 8'h35, 0, 1, 8'hFF, 8'h00);
`ifndef CALL_STACK_EN
        doSimple("opCplain", 8'hC0, 0, 1, 8'h00, 8'h01);
        doSimple("opBplain", 8'hB7, 0, 3, 8'h01, 8'h02);
        doHalt(8'h02, 8'h03);
`else
        doHalt(8'h00, 8'h01);
`endif
        doReset("rstHalt");

        fetchOpcode("midExec", 8'h35, 0, 8'h10, 8'h11);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        midCycle();
        checkOutput("midExec_decodeFlags", flags, 8'h00);
        nextCycle();
        midCycle();
        checkOutput("midExec_execFlags", flags, F_EXE);
        nextCycle();
        doReset("rstExec");

`ifdef CALL_STACK_EN
        doTwoByte("toCall", 8'hE0, 8'h30, 1'b0, 8'h10, 8'h11, 8'h30);
        doTwoByte("call", 8'hC0, 8'h50, 1'b0, 8'h30, 8'h31, 8'h50);
        fetchOpcode("ret", 8'hB0, 0, 8'h50, 8'h51);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        midCycle();
        checkOutput("ret_decodeFlags", flags, F_PCW);
        checkOutput("ret_decodePcIn", pcIn, 8'h32);
        nextCycle();
        checkOutput("ret_finalPc", pcReg, 8'h32);

        doTwoByte("call1", 8'hC0, 8'h60, 1'b0, 8'h32, 8'h33, 8'h60);
        doTwoByte("call2", 8'hC0, 8'h70, 1'b0, 8'h60, 8'h61, 8'h70);
        doTwoByte("call3", 8'hC0, 8'h80, 1'b0, 8'h70, 8'h71, 8'h80);
        doTwoByte("call4", 8'hC0, 8'h90, 1'b0, 8'h80, 8'h81, 8'h90);
        fetchOpcode("call5", 8'hC0, 0, 8'h90, 8'h91);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        midCycle();
        nextCycle();
        applyStimulus(1'b1, 8'hA0, 1'b0, 1'b0);
        midCycle();
        checkOutput("call5_overflowFlags", flags, F_MRD);
        nextCycle();
        midCycle();
        checkOutput("call5_haltFlags", flags, F_HLT);
        nextCycle();
        checkOutput("call5_pcKept", pcReg, 8'h91);
        doReset("rstOverflow");

        fetchOpcode("retEmpty", 8'hB0, 0, 8'h10, 8'h11);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        midCycle();
        checkOutput("retEmpty_decodeFlags", flags, 8'h00);
        nextCycle();
        midCycle();
        checkOutput("retEmpty_haltFlags", flags, F_HLT);
        nextCycle();
        checkOutput("retEmpty_pcKept", pcReg, 8'h11);
        doReset("rstUnderflow");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multi-cycle control FSM that owns the program counter register of the 8-bit processor. It drives the PC's load input and write enable, sequences instruction fetch, decode, operand fetch and execute, and resolves jumps and conditional branches. It sits between instruction memory, the PC register and the execute datapath, and is the PC's only writer.

Parameters:
WIDTH, 8, PC/address/data width
RESET_VECTOR, 8'h00, PC value loaded after reset
STACK_DEPTH, 4, return-stack entries (used only with CALL_STACK_EN)

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
PCOut  in  WIDTH  current PC value from the PC register
Instr  in  WIDTH  memory read data
MemReady  in  1  memory data valid this cycle
Zero  in  1  ALU zero flag
ExecDone  in  1  datapath finished current instruction
PCIn  out  WIDTH  next PC value to the PC register
PCWrite  out  1  PC load enable
MemRead  out  1  memory read request; address is PCOut
IRWrite  out  1  instruction register load strobe
ExecEn  out  1  datapath execute enable
Halted  out  1  processor halted

Behaviour:
- Opcode is Instr[7:4]. JMP=4'hE (2-byte), BZ=4'hD (2-byte), HALT=4'hF; all others are 1-byte, executed by the datapath.
- States: INIT, FETCH, DECODE, FETCH_OP, EXEC, HALT. State and opcode are registered. Outputs are combinational decodes of state and inputs. Outputs not listed for a state are 0, and PCIn=0.
- Reset asserted (any time, including mid-instruction): state=INIT immediately. Outputs: PCWrite=1, PCIn=RESET_VECTOR, others 0.
- INIT: PCWrite=1, PCIn=RESET_VECTOR. Next state FETCH.
- FETCH: MemRead=1. Hold while MemReady=0.
  - When MemReady=1: IRWrite=1, PCWrite=1, PCIn=PCOut+1, Instr[7:4] latched as opcode. Next state DECODE.
- DECODE (1 cycle, no outputs): HALT→HALT; JMP/BZ→FETCH_OP; otherwise→EXEC.
- FETCH_OP: MemRead=1. Hold while MemReady=0.
  - When MemReady=1: PCWrite=1. Next state FETCH.
  - JMP: PCIn=Instr.
  - BZ: PCIn=Instr if Zero=1 (sampled this cycle), else PCOut+1.
- EXEC: ExecEn=1 each cycle. When ExecDone=1, next state FETCH. PC is not written.
- HALT: Halted=1. Held until Reset.
- Arithmetic: PCOut+1 is modulo 2^WIDTH (8'hFF→8'h00). No carry-out.
- MemReady or ExecDone asserted outside its consuming state: ignored.
- Fetch latency with zero wait states: 1-byte instruction = FETCH + DECODE + EXEC (≥1 cycle). Jump = 3 cycles.

Optional Feature:
CALL_STACK_EN
- Defined: adds a STACK_DEPTH-entry return stack.
  - CALL=4'hC (2-byte): in FETCH_OP with MemReady=1, push PCOut+1 and load PCIn=Instr.
  - RET=4'hB (1-byte): in DECODE, PCWrite=1, PCIn=popped value, next state FETCH.
  - Push when full, or pop when empty: no PC write; next state HALT.
  - Reset empties the stack.
  - Simultaneous push and pop is impossible by construction.
- Undefined: 4'hC and 4'hB are ordinary EXEC opcodes; no stack logic is present.

Decomposition:
- Shared package pc_seq_pkg:
  - State encoding localparams (3-bit).
  - Opcode constants OP_JMP, OP_BZ, OP_HALT, OP_CALL, OP_RET.
  - Reset vector default.
- Sub-module pc_return_stack, instantiated only under CALL_STACK_EN:
  - Ports: push, pop, data in/out, full, empty.
  - Pointer-based register array with async reset.
- Everything else lives in pc_sequencer.

Test Plan:
- Reset held 3 cycles, RESET_VECTOR=8'h10 → PCWrite=1, PCIn=8'h10 during reset and in INIT. Next cycle FETCH with MemRead=1.
- PC=8'h10, Instr=8'h35, MemReady after 2 wait cycles → MemRead held 3 cycles, then IRWrite=1 and PCIn=8'h11 for 1 cycle. DECODE, then ExecEn high until ExecDone. FETCH resumes at 8'h11.
- JMP at 8'h20 with operand 8'h80 → PC 8'h21 after opcode, 8'h80 after operand. ExecEn never asserted.
- BZ at 8'h40, operand 8'h90, Zero=0 → PC ends at 8'h42. Repeat with Zero=1 → PC ends at 8'h90.
- Fetch at PCOut=8'hFF → PCIn=8'h00. HALT opcode → Halted=1, PCWrite=0 for 10 cycles. Reset asserted mid-EXEC → state INIT, ExecEn drops immediately.
- With CALL_STACK_EN, STACK_DEPTH=4: CALL 8'h50 from 8'h30 → PC 8'h50. RET → PC 8'h32. Fifth nested CALL → Halted=1. RET on empty stack → Halted=1.
